tsp_result_buffer: RTL and testbench
====================================

// Module: tsp_result_buffer
// PURPOSE
//  Output stage directly downstream of the PD0 three-stage pipeline (TSP).
//  - Captures each TSP result into a FIFO and presents it on a valid/ready port.
//  - The TSP has fixed latency and cannot stall, so this block issues credits.
//  - Upstream may launch an op into the TSP only when a FIFO slot is guaranteed
//    free at the moment that op's result arrives.
// PARAMETERS
//  DWIDTH   32  result width
//  DEPTH    8   FIFO entries; power of two, >= 4
//  LATENCY  3   TSP cycles from issue to res_valid; informational, bounds inflight
// PORTS
//  clock        in   1                 rising-edge clock
//  reset        in   1                 synchronous, active-high
//  issue_req    in   1                 upstream wants to launch an op into the TSP
//  issue_grant  out  1                 op launched this cycle (combinational)
//  res_valid    in   1                 TSP result present this cycle
//  res_data     in   DWIDTH            TSP result
//  out_valid    out  1                 FIFO head valid
//  out_data     out  DWIDTH            FIFO head data
//  out_ready    in   1                 consumer accepts head
//  count        out  $clog2(DEPTH)+1   entries stored
//  inflight     out  $clog2(DEPTH)+1   granted ops not yet returned
//  overflow     out  1                 sticky protocol-error flag
//  stat_pushes  out  32                accepted pushes (see CONFIGURATION)
//  stat_pops    out  32                pops (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, active-high): wr_ptr, rd_ptr, count, inflight, overflow and
//    stats go to 0; out_valid=0; out_data=0. Storage array is not reset.
//  - Reset mid-operation discards stored data and in-flight credits.
//    Results arriving after reset (from ops issued before it) are treated as
//    unexpected and set overflow.
//  - Credit rule:
//      issue_grant = issue_req && !reset && (count + inflight < DEPTH)
//    Uses registered count/inflight only; a same-cycle pop returns no credit.
//  - inflight next value:
//      +1 on grant only; -1 on res_valid only; unchanged on both or neither.
//  - res_valid with inflight==0 (before this cycle's update): overflow<=1.
//    The result is still pushed if space exists; inflight stays 0 (saturates).
//  - Push condition:
//      push = res_valid && (count < DEPTH || pop)
//    Simultaneous push and pop at full is legal.
//    res_valid when full and no pop: data dropped, overflow<=1.
//  - Head (first-word fall-through, no added latency):
//    - out_valid = (count != 0)
//    - out_data  = mem[rd_ptr] when out_valid, else 0
//    - pop = out_valid && out_ready
//  - Latency: a push at edge N makes the entry visible on out_valid after edge N
//    when the FIFO was empty (1-cycle res_valid -> out_valid).
//  - Pointers: log2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
//    count: +1 on push only; -1 on pop only; unchanged on both.
//  - overflow is sticky; cleared only by reset.
//  - Invariant (credit protocol obeyed): count + inflight <= DEPTH, overflow==0.
// CONFIGURATION
//  TSP_BUF_STATS_EN defined:
//    - stat_pushes increments on each push; stat_pops increments on each pop.
//    - Both wrap at 2^32 and reset to 0.
//  TSP_BUF_STATS_EN undefined:
//    - stat_pushes and stat_pops are tied to 0 and no counter flops exist.
//    - All other behaviour is identical.
// TESTING
//  1 Reset: hold reset 3 cycles, issue_req=1
//    -> issue_grant=0, out_valid=0, count=0, inflight=0, overflow=0.
//  2 Single op: grant at cycle 10; res_valid=1, res_data=5 at cycle 13; out_ready=1
//    -> out_valid=1, out_data=5 in cycle 14, popped; count returns to 0.
//  3 Backpressure: out_ready=0, issue_req=1 continuously, TSP model returns
//    each grant 3 cycles later
//    -> exactly 8 grants, then grant=0; count=8, inflight=0.
//  4 Full + simultaneous: at count=8 with res_valid=1 and out_ready=1
//    -> push and pop both occur; count stays 8; overflow=0; FIFO order preserved.
//  5 Ordering/wrap: push 20 values 0x10..0x23 with random out_ready
//    -> outputs appear in order 0x10..0x23; pointers wrap twice; no loss.
//  6 Errors: res_valid with inflight=0 -> overflow=1 next cycle, stays 1 until reset.
//    With TSP_BUF_STATS_EN, after test 5: stat_pushes=20, stat_pops=20.

Source files
------------

// File: rtl/tsp_result_buffer.sv
// Credit-managed result FIFO behind the fixed-latency TSP, with a first-word fall-through head.
// Optional push/pop statistics counters are enabled by defining TSP_BUF_STATS_EN.
module tsp_result_buffer #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_req,
    output logic                       issue_grant,
    input  logic                       res_valid,
    input  logic [DWIDTH-1:0]          res_data,
    output logic                       out_valid,
    output logic [DWIDTH-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic                       overflow,
    output logic [31:0]                stat_pushes,
    output logic [31:0]                stat_pops
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW:0]   FULL_OCC = (CW+1)'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("tsp_result_buffer: DEPTH must be a power of two >= 4");
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("tsp_result_buffer: LATENCY must be >= 1");
    end

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     inflight_q;
    logic              overflow_q;
    logic [CW:0]       occupancy;
    logic              push;
    logic              pop;

    // Credits are judged on registered state only, so a pop this cycle frees nothing yet.
    assign occupancy   = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_grant = issue_req && !reset && (occupancy < FULL_OCC);

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign pop       = out_valid && out_ready;
    assign push      = res_valid && ((count_q < FULL_CNT) || pop);

    assign count    = count_q;
    assign inflight = inflight_q;
    assign overflow = overflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;

            // An unexpected result leaves inflight pinned at zero rather than wrapping.
            if (issue_grant && !res_valid)
                inflight_q <= inflight_q + 1'b1;
            else if (res_valid && !issue_grant && (inflight_q != '0))
                inflight_q <= inflight_q - 1'b1;

            if (res_valid && ((inflight_q == '0) || !push))
                overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= res_data;
    end

`ifdef TSP_BUF_STATS_EN
    logic [31:0] pushes_q;
    logic [31:0] pops_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            pushes_q <= '0;
            pops_q   <= '0;
        end else begin
            if (push) pushes_q <= pushes_q + 1'b1;
            if (pop)  pops_q   <= pops_q + 1'b1;
        end
    end

    assign stat_pushes = pushes_q;
    assign stat_pops   = pops_q;
`else
    assign stat_pushes = '0;
    assign stat_pops   = '0;
`endif

endmodule

// File: tb/tb_tsp_result_buffer.sv
// Directed bench for tsp_result_buffer: vector table for reset/single-op/error cases,
// hand sequences for credit backpressure, full push+pop, and ordering with pointer wrap.
module tb_tsp_result_buffer;
    logic        clock = 1'b0;
    logic        reset;
    logic        issue_req;
    logic        res_valid;
    logic [31:0] res_data;
    logic        out_ready;
    logic        issue_grant;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  count;
    logic [3:0]  inflight;
    logic        overflow;
    logic [31:0] stat_pushes;
    logic [31:0] stat_pops;

    int n_vec = 0;
    int n_err = 0;

    tsp_result_buffer #(.DWIDTH(32), .DEPTH(8), .LATENCY(3)) dut (
        .clock       (clock),
        .reset       (reset),
        .issue_req   (issue_req),
        .issue_grant (issue_grant),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .count       (count),
        .inflight    (inflight),
        .overflow    (overflow),
        .stat_pushes (stat_pushes),
        .stat_pops   (stat_pops)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        req;
        logic        rv;
        logic [31:0] rd;
        logic        rdy;
        logic        g;
        logic        ov;
        logic [31:0] od;
        logic [3:0]  cnt;
        logic [3:0]  inf;
        logic        ovf;
    } vec_t;

    function automatic vec_t mk(logic rst, logic req, logic rv, logic [31:0] rd, logic rdy,
                                logic g, logic ov, logic [31:0] od, logic [3:0] cnt,
                                logic [3:0] inf, logic ovf);
        vec_t v;
        v.rst = rst; v.req = req; v.rv = rv; v.rd = rd; v.rdy = rdy;
        v.g = g; v.ov = ov; v.od = od; v.cnt = cnt; v.inf = inf; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic q, logic v, logic [31:0] d, logic y);
        reset = r; issue_req = q; res_valid = v; res_data = d; out_ready = y;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        tbl[18];
    logic [2:0]  pipe;
    logic        g;
    int          grants;
    int          ret;
    int          issued;
    int          rcv;
    int          cyc;
    logic        rdy;
    logic [31:0] exp_v;
    logic [31:0] drain_exp[8];

    initial begin
        // reset held three cycles with issue_req high, single op, then error cases
        tbl[0]  = mk(1, 1, 0, 0,     0, 0, 0, 0,     0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 0,     0, 0, 0, 0,     0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 0,     0, 0, 0, 0,     0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0,     0, 1, 0, 0,     0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 1, 0);
        tbl[6]  = mk(0, 0, 1, 5,     1, 0, 0, 0,     0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0,     1, 0, 1, 5,     1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0);
        tbl[9]  = mk(0, 0, 1, 'h77,  0, 0, 0, 0,     0, 0, 0);
        tbl[10] = mk(0, 0, 0, 0,     1, 0, 1, 'h77,  1, 0, 1);
        tbl[11] = mk(0, 1, 0, 0,     0, 1, 0, 0,     0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 1, 1);
        tbl[13] = mk(1, 1, 0, 0,     0, 0, 0, 0,     0, 1, 1);
        tbl[14] = mk(0, 0, 1, 'h99,  0, 0, 0, 0,     0, 0, 0);
        tbl[15] = mk(0, 0, 0, 0,     1, 0, 1, 'h99,  1, 0, 1);
        tbl[16] = mk(1, 0, 0, 0,     0, 0, 0, 0,     0, 0, 1);
        tbl[17] = mk(0, 0, 0, 0,     0, 0, 0, 0,     0, 0, 0);

        drive(1, 1, 0, 0, 0);
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].rv, tbl[i].rd, tbl[i].rdy);
            #3;
            chk($sformatf("v%0d_grant", i),     32'(issue_grant), 32'(tbl[i].g));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid),   32'(tbl[i].ov));
            chk($sformatf("v%0d_out_data", i),  out_data,         tbl[i].od);
            chk($sformatf("v%0d_count", i),     32'(count),       32'(tbl[i].cnt));
            chk($sformatf("v%0d_inflight", i),  32'(inflight),    32'(tbl[i].inf));
            chk($sformatf("v%0d_overflow", i),  32'(overflow),    32'(tbl[i].ovf));
            tick();
        end

        // backpressure: TSP model returns every grant three cycles later
        pipe = '0; grants = 0; ret = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 1, pipe[2], pipe[2] ? 32'h100 + 32'(ret) : 32'h0, 0);
            #3;
            g = issue_grant;
            if (g) grants++;
            tick();
            if (pipe[2]) ret++;
            pipe = {pipe[1:0], g};
        end
        drive(0, 1, 0, 0, 0);
        #3;
        chk("bp_grants",   32'(grants),      32'd8);
        chk("bp_grant_lo", 32'(issue_grant), 32'd0);
        chk("bp_count",    32'(count),       32'd8);
        chk("bp_inflight", 32'(inflight),    32'd0);
        chk("bp_overflow", 32'(overflow),    32'd0);
        chk("bp_head",     out_data,         32'h100);
        tick();

        // full FIFO: simultaneous push and pop, then push with no pop is dropped
        drive(0, 0, 1, 32'h1AA, 1);
        #3;
        chk("full_head", out_data,    32'h100);
        chk("full_cnt0", 32'(count),  32'd8);
        tick();
        drive(0, 0, 1, 32'h1BB, 0);
        #3;
        chk("full_cnt1", 32'(count), 32'd8);
        tick();
        drive(0, 0, 0, 0, 0);
        #3;
        chk("full_cnt2", 32'(count), 32'd8);
        tick();
        for (int i = 0; i < 7; i++) drain_exp[i] = 32'h101 + 32'(i);
        drain_exp[7] = 32'h1AA;
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 0, 1);
            #3;
            chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_data", i),  out_data,       drain_exp[i]);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        #3;
        chk("drain_count", 32'(count),     32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_data",  out_data,       32'd0);
        tick();

        drive(1, 0, 0, 0, 0);
        tick();
        tick();

        // ordering across two pointer wraps with random consumer stalls
        pipe = '0; issued = 0; rcv = 0; ret = 0; cyc = 0; exp_v = 32'h10;
        while (rcv < 20 && cyc < 400) begin
            rdy = 1'($urandom_range(0, 1));
            drive(0, issued < 20, pipe[2], pipe[2] ? 32'h10 + 32'(ret) : 32'h0, rdy);
            #3;
            g = issue_grant;
            if (out_valid && out_ready) begin
                chk($sformatf("order%0d", rcv), out_data, exp_v);
                exp_v = exp_v + 1;
                rcv++;
            end
            tick();
            if (g) issued++;
            if (pipe[2]) ret++;
            pipe = {pipe[1:0], g};
            cyc++;
        end
        drive(0, 0, 0, 0, 0);
        #3;
        chk("order_received", 32'(rcv),      32'd20);
        chk("order_overflow", 32'(overflow), 32'd0);
        chk("order_count",    32'(count),    32'd0);
        chk("order_inflight", 32'(inflight), 32'd0);
`ifdef TSP_BUF_STATS_EN
        chk("stat_pushes", stat_pushes, 32'd20);
        chk("stat_pops",   stat_pops,   32'd20);
`else
        chk("stat_pushes", stat_pushes, 32'd0);
        chk("stat_pops",   stat_pops,   32'd0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
